csa_serial_ctrl: RTL and testbench



---
 rtl/csa_pkg.sv | 31 +++
 rtl/csa_slice.sv | 38 +++
 rtl/csa_serial_ctrl.sv | 143 ++++++++++++++
 tb/tb_csa_serial_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csa_pkg
// Description : Shared state encoding, default slice width and a width helper
//               for the serial carry-select/skip adder controller.
// Revision    : 1.0 - initial release
// ============================================================================
package csa_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Default width of the shared adder slice
  localparam int SLICE_DEF = 4;

  // Ceiling log2; returns 0 for values <= 1
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >>> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage : csa_pkg
`default_nettype wire

// File: rtl/csa_slice.sv
`default_nettype none
// ============================================================================
// Module      : csa_slice
// Description : SLICE-bit ripple adder with group propagate and carry-skip
//               mux. Purely combinational; shared across all slices of an
//               operation by the controller.
// Revision    : 1.0 - initial release
// ============================================================================
module csa_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  logic             cin_i,
  output logic [SLICE-1:0] sum_o,
  output logic             carry_o,
  output logic             grp_p_o
);

  logic [SLICE-1:0] prop_w;
  logic [SLICE:0]   carry_w;

  // Ripple chain, group propagate and skip selection of the outgoing carry
  always_comb begin
    prop_w     = a_i ^ b_i;
    carry_w    = '0;
    carry_w[0] = cin_i;
    for (int i = 0; i < SLICE; i++) begin
      carry_w[i+1] = (a_i[i] & b_i[i]) | (prop_w[i] & carry_w[i]);
    end
    sum_o   = prop_w ^ carry_w[SLICE-1:0];
    grp_p_o = &prop_w;
    // When every bit propagates, the incoming carry bypasses the ripple chain
    carry_o = grp_p_o ? cin_i : carry_w[SLICE];
  end

endmodule : csa_slice
`default_nettype wire

// File: rtl/csa_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : csa_serial_ctrl
// Description : Multi-cycle WIDTH-bit adder that walks one shared SLICE-bit
//               carry-select/skip slice from LSB to MSB, with valid/ready
//               handshakes on both sides and a count of skipped slices.
// Revision    : 1.0 - initial release
// ============================================================================
module csa_serial_ctrl
  import csa_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = SLICE_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush_i,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  input  logic [WIDTH-1:0]                  a_i,
  input  logic [WIDTH-1:0]                  b_i,
  input  logic                              cin_i,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic [WIDTH-1:0]                  sum_o,
  output logic                              cout_o,
  output logic [clog2(WIDTH/SLICE+1)-1:0]   skip_cnt_o
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (clog2(NSLICE) > 0) ? clog2(NSLICE) : 1;
  localparam int CNT_W  = clog2(NSLICE + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  // Refuse to build a controller whose width is not whole slices
  if ((WIDTH % SLICE) != 0) begin : g_width_check
    $fatal(1, "csa_serial_ctrl: WIDTH must be a multiple of SLICE");
  end

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic [CNT_W-1:0] skip_cnt_q;
  logic             out_valid_q;

  logic [SLICE-1:0] slice_sum_d;
  logic             carry_d;
  logic             grp_p_d;

  // Single shared slice; operand slice selection happens here in the controller
  csa_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .a_i     (a_q[idx_q*SLICE +: SLICE]),
    .b_i     (b_q[idx_q*SLICE +: SLICE]),
    .cin_i   (carry_q),
    .sum_o   (slice_sum_d),
    .carry_o (carry_d),
    .grp_p_o (grp_p_d)
  );

  // Controller FSM with all result outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      skip_cnt_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // flush in IDLE only blocks the capture
          if (!flush_i && in_valid_i) begin
            a_q        <= a_i;
            b_q        <= b_i;
            carry_q    <= cin_i;
            sum_q      <= '0;
            skip_cnt_q <= '0;
            idx_q      <= '0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          if (flush_i) begin
            sum_q       <= '0;
            cout_q      <= 1'b0;
            skip_cnt_q  <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end else begin
            sum_q[idx_q*SLICE +: SLICE] <= slice_sum_d;
            carry_q <= carry_d;
            if (grp_p_d) begin
              skip_cnt_q <= skip_cnt_q + CNT_W'(1);
            end
            if (idx_q == LAST_IDX) begin
              cout_q      <= carry_d;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        DONE: begin
          if (flush_i) begin
            sum_q       <= '0;
            cout_q      <= 1'b0;
            skip_cnt_q  <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = out_valid_q;
  assign sum_o       = sum_q;
  assign cout_o      = cout_q;
  assign skip_cnt_o  = skip_cnt_q;

endmodule : csa_serial_ctrl
`default_nettype wire

// File: tb/tb_csa_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_csa_serial_ctrl
// Description : Directed self-checking bench for csa_serial_ctrl (16-bit,
//               4-bit slice) with hand-computed expected results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csa_serial_ctrl;

  localparam int WIDTH  = 16;
  localparam int SLICE  = 4;
  localparam int NSLICE = WIDTH / SLICE;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             cin_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] sum_o;
  logic             cout_o;
  logic [2:0]       skip_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  csa_serial_ctrl #(
    .WIDTH (WIDTH),
    .SLICE (SLICE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .cin_i       (cin_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .sum_o       (sum_o),
    .cout_o      (cout_o),
    .skip_cnt_o  (skip_cnt_o)
  );

  always #5 clk = ~clk;

  // One comparison: counts it, and on mismatch counts and reports it
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands, check the accept, RUN latency and the delivered result.
  // Leaves the controller in DONE with out_ready low.
  task automatic do_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                       input logic ci, input logic [15:0] es, input logic ec,
                       input logic [2:0] ek);
    a_i        = av;
    b_i        = bv;
    cin_i      = ci;
    in_valid_i = 1'b1;
    chk({tag, ".in_ready_pre"}, in_ready_o, 1);
    tick();
    in_valid_i = 1'b0;
    // Operands must have been captured; scramble the inputs
    a_i   = 16'hDEAD;
    b_i   = 16'hBEEF;
    cin_i = ~ci;
    chk({tag, ".in_ready_run"}, in_ready_o, 0);
    for (int k = 1; k < NSLICE; k++) begin
      tick();
      chk($sformatf("%s.out_valid_early%0d", tag, k), out_valid_o, 0);
    end
    tick();
    chk({tag, ".out_valid"}, out_valid_o, 1);
    chk({tag, ".sum"}, sum_o, es);
    chk({tag, ".cout"}, cout_o, ec);
    chk({tag, ".skip_cnt"}, skip_cnt_o, ek);
    chk({tag, ".in_ready_done"}, in_ready_o, 0);
  endtask

  // Consume the result and confirm return to IDLE
  task automatic take_out(input string tag);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    chk({tag, ".out_valid_after"}, out_valid_o, 0);
    chk({tag, ".in_ready_after"}, in_ready_o, 1);
  endtask

  initial begin
    rst         = 1'b1;
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    a_i         = '0;
    b_i         = '0;
    cin_i       = 1'b0;
    out_ready_i = 1'b0;
    tick();
    tick();
    // Reset state
    chk("rst.in_ready", in_ready_o, 1);
    chk("rst.out_valid", out_valid_o, 0);
    chk("rst.sum", sum_o, 0);
    chk("rst.cout", cout_o, 0);
    chk("rst.skip_cnt", skip_cnt_o, 0);
    rst = 1'b0;
    tick();

    // Simple add
    do_op("add3_5", 16'h0003, 16'h0005, 1'b0, 16'h0008, 1'b0, 3'd0);
    take_out("add3_5");

    // Every slice propagates, carry skips all four slices
    do_op("skipall", 16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 3'd4);
    take_out("skipall");

    // Exactly one skipped slice
    do_op("skip1", 16'h00F0, 16'h0000, 1'b1, 16'h00F1, 1'b0, 3'd1);
    take_out("skip1");

    // Carry out of the top slice only
    do_op("topc", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 3'd0);
    take_out("topc");

    // Full generate then back-to-back with a waiting producer
    do_op("ffff", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 3'd0);
    a_i         = 16'h0001;
    b_i         = 16'h0009;
    cin_i       = 1'b1;
    in_valid_i  = 1'b1;
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    chk("b2b.not_accepted_in_done", in_ready_o, 1);
    chk("b2b.out_valid_dropped", out_valid_o, 0);
    do_op("b2b", 16'h0001, 16'h0009, 1'b1, 16'h000B, 1'b0, 3'd0);

    // Backpressure: result held while out_ready is low
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("bp.out_valid%0d", k), out_valid_o, 1);
      chk($sformatf("bp.sum%0d", k), sum_o, 16'h000B);
      chk($sformatf("bp.in_ready%0d", k), in_ready_o, 0);
    end
    take_out("bp");

    // Asynchronous reset while idx==2
    a_i        = 16'h1234;
    b_i        = 16'h4321;
    cin_i      = 1'b0;
    in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    tick();
    tick();
    chk("rstmid.partial_sum", sum_o, 16'h0055);
    #1;
    rst = 1'b1;
    #1;
    chk("rstmid.sum", sum_o, 0);
    chk("rstmid.out_valid", out_valid_o, 0);
    chk("rstmid.skip_cnt", skip_cnt_o, 0);
    chk("rstmid.cout", cout_o, 0);
    #1;
    rst = 1'b0;
    tick();
    chk("rstmid.in_ready", in_ready_o, 1);
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < NSLICE + 2; k++) begin
        tick();
        if (out_valid_o) seen++;
      end
      chk("rstmid.no_out_valid", seen, 0);
    end

    // flush in IDLE blocks capture
    a_i        = 16'h1111;
    b_i        = 16'h2222;
    in_valid_i = 1'b1;
    flush_i    = 1'b1;
    tick();
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    chk("flush_idle.in_ready", in_ready_o, 1);

    // flush during RUN at idx==1
    a_i        = 16'h0F0F;
    b_i        = 16'hF0F0;
    cin_i      = 1'b1;
    in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush_run.in_ready", in_ready_o, 1);
    chk("flush_run.out_valid", out_valid_o, 0);
    chk("flush_run.sum", sum_o, 0);
    chk("flush_run.skip_cnt", skip_cnt_o, 0);
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < NSLICE + 2; k++) begin
        tick();
        if (out_valid_o) seen++;
      end
      chk("flush_run.no_out_valid", seen, 0);
    end
    do_op("after_flush", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 3'd0);

    // flush in DONE discards the result
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush_done.out_valid", out_valid_o, 0);
    chk("flush_done.sum", sum_o, 0);
    chk("flush_done.in_ready", in_ready_o, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_csa_serial_ctrl
`default_nettype wire
